// File: rtl/any1_rob_ctrl.sv
// Reorder-buffer controller for the ANY1 core: tracks per-entry valid/done/exception state,
// hands out rids on dispatch, retires in order, and rolls back on branch or exception flush.
module any1_rob_ctrl #(
   parameter int unsigned ENTRIES    = 8,
   parameter int unsigned DISP_WIDTH = 2,
   parameter int unsigned FU_PORTS   = 2,
   parameter int unsigned CMT_WIDTH  = 2
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic [$clog2(DISP_WIDTH+1)-1:0]          alloc_cnt_i,
   output logic                                     alloc_ok_o,
   output logic [DISP_WIDTH*$clog2(ENTRIES)-1:0]    alloc_rid_o,
   input  logic [FU_PORTS-1:0]                      fu_done_i,
   input  logic [FU_PORTS*$clog2(ENTRIES)-1:0]      fu_rid_i,
   input  logic [FU_PORTS-1:0]                      fu_exc_i,
   input  logic                                     flush_i,
   input  logic [$clog2(ENTRIES)-1:0]               flush_rid_i,
   output logic [CMT_WIDTH-1:0]                     cmt_v_o,
   output logic [CMT_WIDTH*$clog2(ENTRIES)-1:0]     cmt_rid_o,
   output logic                                     exc_o,
   output logic [$clog2(ENTRIES)-1:0]               exc_rid_o,
   output logic [$clog2(ENTRIES):0]                 count_o,
   output logic                                     full_o,
   output logic                                     empty_o
);

   localparam int unsigned RIDW = $clog2(ENTRIES);
   localparam int unsigned CW1  = RIDW + 1;

   logic [ENTRIES-1:0] v_q, done_q, exc_q;
   logic [ENTRIES-1:0] v_n, done_n, exc_n;
   logic [RIDW-1:0]    head_q, tail_q, head_n, tail_n;
   logic [CW1-1:0]     count_q, count_n;

   logic [ENTRIES-1:0] cmp_hit, cmp_exc;
   logic [CW1-1:0]     ret_cnt;
   logic               chain;
   logic [RIDW-1:0]    crid;
   logic [CW1-1:0]     free_cnt;
   logic [RIDW-1:0]    fr_off;
   logic [RIDW-1:0]    ent_off;

   assign count_o  = count_q;
   assign full_o   = (count_q == CW1'(ENTRIES));
   assign empty_o  = (count_q == '0);
   assign free_cnt = CW1'(ENTRIES) - count_q;

   assign exc_o     = v_q[head_q] & done_q[head_q] & exc_q[head_q];
   assign exc_rid_o = exc_o ? head_q : '0;

   assign alloc_ok_o = !rst_i && (alloc_cnt_i != '0) && (32'(free_cnt) >= 32'(alloc_cnt_i))
                       && !flush_i && !exc_o;

   always_comb begin
      alloc_rid_o = '0;
      for (int unsigned k = 0; k < DISP_WIDTH; k++) begin
         if (alloc_ok_o) alloc_rid_o[k*RIDW +: RIDW] = tail_q + RIDW'(k);
      end
   end

   // Retirement stops at the first slot that is not cleanly done; later slots cannot leapfrog it.
   always_comb begin
      cmt_v_o   = '0;
      cmt_rid_o = '0;
      ret_cnt   = '0;
      chain     = !exc_o;
      crid      = '0;
      for (int unsigned k = 0; k < CMT_WIDTH; k++) begin
         crid = head_q + RIDW'(k);
         if (chain && (CW1'(k) < count_q) && v_q[crid] && done_q[crid] && !exc_q[crid]) begin
            cmt_v_o[k]                = 1'b1;
            cmt_rid_o[k*RIDW +: RIDW] = crid;
            ret_cnt                   = ret_cnt + 1'b1;
         end else begin
            chain = 1'b0;
         end
      end
   end

   // Per-entry merge of all completion ports; same-rid hits OR their exception bits.
   always_comb begin
      cmp_hit = '0;
      cmp_exc = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         for (int unsigned p = 0; p < FU_PORTS; p++) begin
            if (fu_done_i[p] && (fu_rid_i[p*RIDW +: RIDW] == RIDW'(i))) begin
               cmp_hit[i] = 1'b1;
               cmp_exc[i] = cmp_exc[i] | fu_exc_i[p];
            end
         end
      end
   end

   always_comb begin
      v_n     = v_q;
      done_n  = done_q;
      exc_n   = exc_q;
      head_n  = head_q;
      tail_n  = tail_q;
      count_n = count_q;
      fr_off  = flush_rid_i - head_q;
      ent_off = '0;

      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (v_q[i] && cmp_hit[i]) begin
            done_n[i] = 1'b1;
            exc_n[i]  = cmp_exc[i];
         end
      end

      if (exc_o) begin
         v_n     = '0;
         tail_n  = head_q;
         count_n = '0;
      end else begin
         for (int unsigned k = 0; k < CMT_WIDTH; k++) begin
            if (cmt_v_o[k]) v_n[head_q + RIDW'(k)] = 1'b0;
         end
         head_n = head_q + RIDW'(ret_cnt);

         if (flush_i) begin
            // Younger-than-branch test uses age relative to head so it works across the wrap.
            for (int unsigned i = 0; i < ENTRIES; i++) begin
               ent_off = RIDW'(i) - head_q;
               if (ent_off > fr_off) v_n[i] = 1'b0;
            end
            tail_n  = flush_rid_i + 1'b1;
            count_n = CW1'(fr_off) + 1'b1 - ret_cnt;
         end else if (alloc_ok_o) begin
            for (int unsigned k = 0; k < DISP_WIDTH; k++) begin
               if (32'(k) < 32'(alloc_cnt_i)) begin
                  v_n[tail_q + RIDW'(k)]    = 1'b1;
                  done_n[tail_q + RIDW'(k)] = 1'b0;
                  exc_n[tail_q + RIDW'(k)]  = 1'b0;
               end
            end
            tail_n  = tail_q + RIDW'(alloc_cnt_i);
            count_n = count_q - ret_cnt + CW1'(alloc_cnt_i);
         end else begin
            count_n = count_q - ret_cnt;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         v_q     <= '0;
         done_q  <= '0;
         exc_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         v_q     <= v_n;
         done_q  <= done_n;
         exc_q   <= exc_n;
         head_q  <= head_n;
         tail_q  <= tail_n;
         count_q <= count_n;
      end
   end

endmodule
